alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised next-generation ALU for the MIPS datapath.
- Single-cycle ops (and, or, add, sub, nor, slt, sltu) are combinational on ALURes and zero.
- Adds an iterative multi-cycle multiply/divide unit with start/busy/done handshake and internal HI/LO result registers, read back through ALUCtr codes.
- Sits in the EX stage; the controller stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, even).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- input1  input  WIDTH  operand A (rs)
- input2  input  WIDTH  operand B (rt)
- ALUCtr  input  4  operation select
- start  input  1  launch mul/div; sampled at clk edge, only for codes 1001/1010/1011/1101
- ALURes  output  WIDTH  combinational result
- zero  output  1  ALURes == 0
- overflow  output  1  signed overflow of add/sub; 0 for all other codes
- busy  output  1  mul/div in progress
- done  output  1  one-cycle pulse when HI/LO are written
- div_zero  output  1  registered; set by divide with input2 == 0, cleared by next accepted start

Behaviour:
- Reset: busy=0, done=0, div_zero=0, HI=0, LO=0, iteration counter=0. Reset mid-operation aborts the op: no done pulse, HI/LO stay 0.
- Combinational codes:
  - 0000 and; 0001 or; 0010 add; 0110 sub; 1100 nor.
  - 0111 slt, signed: WIDTH-1 zeros then LSB result.
  - 1000 sltu, unsigned.
  - 1110 mfhi returns HI; 1111 mflo returns LO.
  - Mul/div codes and undefined codes return ALURes=0.
- Combinational results are available regardless of busy. mfhi/mflo during busy return the pre-operation HI/LO.
- Arithmetic: add/sub wrap modulo 2^WIDTH. overflow = operand signs equal (add) / differ (sub) and result sign differs from input1.
- Multi-cycle codes: 1001 mult (signed), 1010 multu, 1011 div (signed), 1101 divu.
- Handshake:
  - start=1 with busy=0 and a multi-cycle code at edge E0 latches the operands and op.
  - busy=1 from after E0 through edge E_WIDTH.
  - At E_WIDTH: HI/LO written, busy→0, done=1 for exactly one cycle.
  - Latency is WIDTH cycles; back-to-back start is accepted in the done cycle.
  - start while busy=1 is ignored; the in-flight op is unaffected.
  - start with a non-multi-cycle code is ignored.
- FSM states: IDLE → RUN (counter 0..WIDTH-1, one bit per cycle) → IDLE.
  - Multiply is shift-add on magnitudes; divide is restoring division on magnitudes.
  - Signs are fixed up on the final write.
- Mult: {HI,LO} = full 2·WIDTH product.
- Div: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
- Div boundary cases:
  - Divisor 0: HI=input1, LO=all ones, div_zero=1, same latency.
  - Signed MIN / −1: LO=MIN, HI=0, div_zero=0.
- div_zero holds until the next accepted start.

Test Plan:
1. input1=aaaabbbb, input2=11112222, codes 0000/0001/0010/0110/1100 → 00002222 / bbbbbbbb / bbbbdddd / 99999999 / 44444444. Code 0110 with both operands aaaabbbb → ALURes=0, zero=1.
2. input1=11112222, input2=aaaabbbb: slt → 0 (input2 negative), sltu → 1. add 7fffffff+00000001 → 80000000, overflow=1. add ffffffff+00000001 → 0, overflow=0, zero=1.
3. mult ffffffff×00000002 → done exactly 32 cycles after start, HI=ffffffff, LO=fffffffe. multu on the same operands → HI=00000001, LO=fffffffe. mfhi/mflo read back these values.
4. div fffffff9/00000002 → LO=fffffffd, HI=ffffffff. divu 00000064/00000007 → LO=0000000e, HI=00000002. div 80000000/ffffffff → LO=80000000, HI=0.
5. div 00001234/0 → HI=00001234, LO=ffffffff, div_zero=1. Next mult start clears div_zero.
6. Issue mult, then a second start at cycle 5 with different operands → ignored; first result committed. New start, then reset_n=0 at cycle 10 → busy=0, HI=LO=0, no done.

Source files
------------

// File: rtl/alu_muldiv.sv
// MIPS EX-stage ALU: single-cycle logic/arith ops on ALURes/zero, plus an
// iterative mul/div unit (one bit per cycle) writing internal HI/LO, read back
// through the mfhi/mflo codes. The controller stalls on busy.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic [3:0]       ALUCtr,
   input  logic             start,
   output logic [WIDTH-1:0] ALURes,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                          OP_SUB = 4'b0110, OP_NOR = 4'b1100, OP_SLT = 4'b0111,
                          OP_SLTU = 4'b1000, OP_MFHI = 4'b1110, OP_MFLO = 4'b1111,
                          OP_MULT = 4'b1001, OP_MULTU = 4'b1010,
                          OP_DIV = 4'b1011, OP_DIVU = 4'b1101;

   typedef enum logic {IDLE, RUN} state_t;

   // operation captured at the accepting edge; operands held as magnitudes
   typedef struct packed {
      logic             mul;
      logic             neg_a;
      logic             neg_b;
      logic             b_zero;
      logic [WIDTH-1:0] a_raw;
      logic [WIDTH-1:0] mag_b;
   } md_req_t;

   state_t           state;
   md_req_t          req;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hi, lo;
   logic [WIDTH-1:0] hi_acc, lo_acc;

   logic             is_md, is_sgn, accept;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum, div_sh, div_trial;
   logic [WIDTH-1:0] nxt_hi, nxt_lo, fin_hi, fin_lo, quo, rem;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] sum, diff;

   assign is_md  = (ALUCtr == OP_MULT) || (ALUCtr == OP_MULTU) ||
                   (ALUCtr == OP_DIV)  || (ALUCtr == OP_DIVU);
   assign is_sgn = (ALUCtr == OP_MULT) || (ALUCtr == OP_DIV);
   assign accept = start && is_md && (state == IDLE);
   assign mag_a  = (is_sgn && input1[WIDTH-1]) ? -input1 : input1;
   assign mag_b  = (is_sgn && input2[WIDTH-1]) ? -input2 : input2;

   // one iteration: shift-add for multiply, restoring step for divide
   always_comb begin
      mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, req.mag_b} : '0);
      div_sh    = {hi_acc, lo_acc[WIDTH-1]};
      div_trial = div_sh - {1'b0, req.mag_b};
      if (req.mul) begin
         nxt_hi = mul_sum[WIDTH:1];
         nxt_lo = {mul_sum[0], lo_acc[WIDTH-1:1]};
      end else if (!div_trial[WIDTH]) begin
         nxt_hi = div_trial[WIDTH-1:0];
         nxt_lo = {lo_acc[WIDTH-2:0], 1'b1};
      end else begin
         nxt_hi = div_sh[WIDTH-1:0];
         nxt_lo = {lo_acc[WIDTH-2:0], 1'b0};
      end
   end

   // sign fix-up applied to the last iteration's result; divide-by-zero override
   always_comb begin
      prod = {nxt_hi, nxt_lo};
      if (req.neg_a ^ req.neg_b) prod = -prod;
      quo = (req.neg_a ^ req.neg_b) ? -nxt_lo : nxt_lo;
      rem = req.neg_a ? -nxt_hi : nxt_hi;
      if (req.mul) begin
         fin_hi = prod[2*WIDTH-1:WIDTH];
         fin_lo = prod[WIDTH-1:0];
      end else if (req.b_zero) begin
         fin_hi = req.a_raw;
         fin_lo = '1;
      end else begin
         fin_hi = rem;
         fin_lo = quo;
      end
   end

   // single-cycle datapath, independent of the mul/div unit
   always_comb begin
      sum      = input1 + input2;
      diff     = input1 - input2;
      ALURes   = '0;
      overflow = 1'b0;
      case (ALUCtr)
         OP_AND:  ALURes = input1 & input2;
         OP_OR:   ALURes = input1 | input2;
         OP_NOR:  ALURes = ~(input1 | input2);
         OP_ADD: begin
            ALURes   = sum;
            overflow = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
         end
         OP_SUB: begin
            ALURes   = diff;
            overflow = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
         end
         OP_SLT:  ALURes = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)};
         OP_SLTU: ALURes = {{(WIDTH-1){1'b0}}, input1 < input2};
         OP_MFHI: ALURes = hi;
         OP_MFLO: ALURes = lo;
         default: ALURes = '0;
      endcase
   end

   assign zero = (ALURes == '0);

   // mul/div FSM: IDLE accepts a start, RUN iterates WIDTH times then commits HI/LO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         req      <= '0;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         hi_acc   <= '0;
         lo_acc   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  req.mul    <= (ALUCtr == OP_MULT) || (ALUCtr == OP_MULTU);
                  req.neg_a  <= is_sgn && input1[WIDTH-1];
                  req.neg_b  <= is_sgn && input2[WIDTH-1];
                  req.b_zero <= (input2 == '0);
                  req.a_raw  <= input1;
                  req.mag_b  <= mag_b;
                  hi_acc     <= '0;
                  lo_acc     <= mag_a;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  div_zero   <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               hi_acc <= nxt_hi;
               lo_acc <= nxt_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  hi       <= fin_hi;
                  lo       <= fin_lo;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  div_zero <= !req.mul && req.b_zero;
                  cnt      <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: vector table for single-cycle codes, hand sequences for
// mul/div corner cases, randomized traffic against an arithmetic reference model.
module tb_alu_muldiv;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] input1 = '0, input2 = '0;
   logic [3:0]   ALUCtr = '0;
   logic         start = 1'b0;
   logic [W-1:0] ALURes;
   logic         zero, overflow, busy, done, div_zero;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   logic         m_dz = 1'b0;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .input1(input1), .input2(input2),
      .ALUCtr(ALUCtr), .start(start), .ALURes(ALURes), .zero(zero),
      .overflow(overflow), .busy(busy), .done(done), .div_zero(div_zero));

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [3:0]   ctr;
      logic [W-1:0] a, b, res;
      logic         z, ov;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: plain integer arithmetic on sign/zero-extended operands
   function automatic void md_model(input logic [3:0] op, input logic [W-1:0] a, b,
                                    output logic [W-1:0] hi, lo, output logic dz);
      longint sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      hi = '0;
      lo = '0;
      if (op == 4'b1001 || op == 4'b1010) begin
         if (op == 4'b1001) p = 64'(sa * sb);
         else p = {32'b0, a} * {32'b0, b};
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == '0) begin
         hi = a; lo = '1; dz = 1'b1;
      end else if (op == 4'b1011) begin
         lo = 32'(sa / sb);
         hi = 32'(sa % sb);
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endfunction

   function automatic logic [W:0] comb_model(input logic [3:0] op, input logic [W-1:0] a, b);
      longint sa, sb, s;
      logic [W-1:0] r;
      logic ov;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0;
      ov = 1'b0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b1100: r = ~(a | b);
         4'b0010: begin s = sa + sb; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'b0110: begin s = sa - sb; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
         4'b1000: r = (a < b) ? 32'd1 : 32'd0;
         4'b1110: r = m_hi;
         4'b1111: r = m_lo;
         default: r = '0;
      endcase
      return {ov, r};
   endfunction

   // launch one mul/div, verify busy/latency/mfhi-during-busy, then HI/LO/div_zero
   task automatic run_md(input string name, input logic [3:0] op, input logic [W-1:0] a, b);
      logic [W-1:0] ehi, elo;
      logic edz;
      int n;
      md_model(op, a, b, ehi, elo, edz);
      input1 = a; input2 = b; ALUCtr = op; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; ALUCtr = 4'b1110; input1 = ~a;
      #1;
      chk({name, " busy"}, busy, 1'b1);
      chk({name, " dz clr"}, div_zero, 1'b0);
      chk({name, " hi during busy"}, ALURes, m_hi);
      n = 0;
      while (n < 3 * W) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
      end
      chk({name, " latency"}, n, W);
      chk({name, " busy end"}, busy, 1'b0);
      ALUCtr = 4'b1110; #1;
      chk({name, " hi"}, ALURes, ehi);
      ALUCtr = 4'b1111; #1;
      chk({name, " lo"}, ALURes, elo);
      chk({name, " div_zero"}, div_zero, edz);
      m_hi = ehi; m_lo = elo; m_dz = edz;
      @(posedge clk); #1;
      chk({name, " done pulse"}, done, 1'b0);
   endtask

   vec_t vt[$];

   initial begin
      logic [W:0] e;
      logic [3:0] codes [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111,
                                 4'b1000, 4'b1110, 4'b1111, 4'b0011, 4'b1001};
      logic [3:0] mdops [4] = '{4'b1001, 4'b1010, 4'b1011, 4'b1101};
      vt.push_back('{"and",   4'b0000, 32'haaaabbbb, 32'h11112222, 32'h00002222, 1'b0, 1'b0});
      vt.push_back('{"or",    4'b0001, 32'haaaabbbb, 32'h11112222, 32'hbbbbbbbb, 1'b0, 1'b0});
      vt.push_back('{"add",   4'b0010, 32'haaaabbbb, 32'h11112222, 32'hbbbbdddd, 1'b0, 1'b0});
      vt.push_back('{"sub",   4'b0110, 32'haaaabbbb, 32'h11112222, 32'h99999999, 1'b0, 1'b0});
      vt.push_back('{"nor",   4'b1100, 32'haaaabbbb, 32'h11112222, 32'h44444444, 1'b0, 1'b0});
      vt.push_back('{"subeq", 4'b0110, 32'haaaabbbb, 32'haaaabbbb, 32'h00000000, 1'b1, 1'b0});
      vt.push_back('{"slt",   4'b0111, 32'h11112222, 32'haaaabbbb, 32'h00000000, 1'b1, 1'b0});
      vt.push_back('{"sltu",  4'b1000, 32'h11112222, 32'haaaabbbb, 32'h00000001, 1'b0, 1'b0});
      vt.push_back('{"addov", 4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
      vt.push_back('{"addwr", 4'b0010, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
      vt.push_back('{"subov", 4'b0110, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b1});
      vt.push_back('{"undef", 4'b0011, 32'h12345678, 32'h1, 32'h00000000, 1'b1, 1'b0});
      vt.push_back('{"mdcode",4'b1001, 32'h12345678, 32'h2, 32'h00000000, 1'b1, 1'b0});

      // reset state
      #12;
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst div_zero", div_zero, 1'b0);
      ALUCtr = 4'b1110; #1; chk("rst hi", ALURes, 0);
      ALUCtr = 4'b1111; #1; chk("rst lo", ALURes, 0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      foreach (vt[i]) begin
         input1 = vt[i].a; input2 = vt[i].b; ALUCtr = vt[i].ctr; #1;
         chk({vt[i].name, " res"}, ALURes, vt[i].res);
         chk({vt[i].name, " zero"}, zero, vt[i].z);
         chk({vt[i].name, " ov"}, overflow, vt[i].ov);
      end

      // start with a non-mul/div code is ignored
      ALUCtr = 4'b0010; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk("nonmd start", busy, 1'b0);

      run_md("mult", 4'b1001, 32'hffffffff, 32'h00000002);
      chk("mult hi const", m_hi, 32'hffffffff);
      run_md("multu", 4'b1010, 32'hffffffff, 32'h00000002);
      chk("multu hi const", m_hi, 32'h00000001);
      run_md("div", 4'b1011, 32'hfffffff9, 32'h00000002);
      run_md("divu", 4'b1101, 32'h00000064, 32'h00000007);
      run_md("divmin", 4'b1011, 32'h80000000, 32'hffffffff);
      run_md("div0", 4'b1011, 32'h00001234, 32'h00000000);
      run_md("mult after div0", 4'b1001, 32'h00000003, 32'hfffffffb);

      // a start while busy is ignored; first op commits its own result
      begin
         logic [W-1:0] ehi, elo; logic edz; int n;
         md_model(4'b1001, 32'h00012345, 32'h00054321, ehi, elo, edz);
         input1 = 32'h00012345; input2 = 32'h00054321; ALUCtr = 4'b1001; start = 1'b1;
         @(posedge clk); #1; start = 1'b0;
         n = 0;
         repeat (4) begin @(posedge clk); #1; n++; end
         input1 = 32'h7; input2 = 32'h9; ALUCtr = 4'b1010; start = 1'b1;
         @(posedge clk); #1; start = 1'b0; n++;
         while (n < 3 * W && !done) begin @(posedge clk); #1; n++; end
         chk("ignored latency", n, W);
         ALUCtr = 4'b1110; #1; chk("ignored hi", ALURes, ehi);
         ALUCtr = 4'b1111; #1; chk("ignored lo", ALURes, elo);
         m_hi = ehi; m_lo = elo;
         @(posedge clk); #1;
         chk("ignored no relaunch", busy, 1'b0);
      end

      // reset mid-operation aborts without a done pulse
      begin
         int seen;
         input1 = 32'h00000064; input2 = 32'h00000007; ALUCtr = 4'b1101; start = 1'b1;
         @(posedge clk); #1; start = 1'b0;
         repeat (9) @(posedge clk);
         #2 reset_n = 1'b0; #1;
         chk("abort busy", busy, 1'b0);
         ALUCtr = 4'b1110; #1; chk("abort hi", ALURes, 0);
         ALUCtr = 4'b1111; #1; chk("abort lo", ALURes, 0);
         @(negedge clk); reset_n = 1'b1;
         m_hi = '0; m_lo = '0; m_dz = 1'b0;
         seen = 0;
         repeat (W + 5) begin @(posedge clk); #1; if (done || busy) seen++; end
         chk("abort no done", seen, 0);
      end

      // randomized mul/div against the reference model
      for (int k = 0; k < 16; k++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         b = $urandom;
         if (k % 5 == 1) b = '0;
         if (k % 4 == 2) b = $urandom_range(1, 20);
         if (k % 7 == 3) a = 32'h80000000;
         run_md("rand md", mdops[$urandom_range(0, 3)], a, b);
      end

      // randomized single-cycle codes, including mfhi/mflo of the last result
      for (int k = 0; k < 60; k++) begin
         input1 = $urandom; input2 = $urandom;
         if (k % 6 == 0) input2 = input1;
         ALUCtr = codes[$urandom_range(0, 10)];
         #1;
         e = comb_model(ALUCtr, input1, input2);
         chk("rand res", ALURes, e[W-1:0]);
         chk("rand zero", zero, e[W-1:0] == '0);
         chk("rand ov", overflow, e[W]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // global watchdog so the bench always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
